serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor. Computes D = A - B one bit per clock, LSB first, with a registered borrow.
- It is the subtracting counterpart of the team's adder datapath blocks and serves area-constrained paths where a full ripple subtractor is not wanted.
- Operands enter through a valid/ready request interface. The result leaves through a valid/ready response interface and is held until accepted.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands A/B are presented
- in_ready  output  1  block can accept operands (high only in IDLE)
- A  input  WIDTH  minuend, sampled on the input handshake
- B  input  WIDTH  subtrahend, sampled on the input handshake
- out_valid  output  1  D/BOUT are valid (high only in DONE)
- out_ready  input  1  consumer accepts the result
- D  output  WIDTH  difference, (A - B) mod 2^WIDTH
- BOUT  output  1  final borrow; 1 iff A < B (unsigned)

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; in_ready=1; out_valid=0; D=0; BOUT=0.
  - Internal shift registers, bit counter and borrow are cleared.
  - Reset overrides all other activity, including mid-SHIFT or DONE; any in-flight operation is discarded and no result is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - If in_valid=1: latch A into a_sh and B into b_sh, set borrow=0 and cnt=0, go to SHIFT.
  - If in_valid=0: stay in IDLE.
- SHIFT (in_ready=0, out_valid=0), once per cycle:
  - diff bit d = a_sh[0] ^ b_sh[0] ^ borrow.
  - borrow_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow).
  - d shifts into the result register MSB-side, so after WIDTH shifts bit i holds diff bit i.
  - a_sh and b_sh shift right by one; cnt increments.
  - When cnt reaches WIDTH-1 in a cycle, that is the last shift: D takes the final result, BOUT=borrow_next, next state is DONE.
  - in_valid is ignored in SHIFT; operands are never re-sampled.
- DONE:
  - out_valid=1; D and BOUT are held stable.
  - If out_ready=1: go to IDLE, and out_valid drops the next cycle.
  - If out_ready=0: stay in DONE indefinitely (backpressure).
- Latency:
  - Input handshake at edge k gives out_valid=1 after edge k+WIDTH.
  - Throughput is one result per WIDTH+2 cycles with out_ready tied high.
  - No combinational path from in_valid to out_valid, or from out_ready to in_ready.
- Output holding:
  - D/BOUT keep their last result after leaving DONE, until the next SHIFT completes or reset.
  - Only values qualified by out_valid are specified.
- Boundaries:
  - WIDTH=1: exactly one SHIFT cycle.
  - A=B gives D=0, BOUT=0.
  - A=0, B=2^WIDTH-1 gives D=1, BOUT=1.
  - The counter is sized ceil(log2(WIDTH+1)) and never wraps during an operation.
- Width/arithmetic: unsigned modulo-2^WIDTH. BOUT is the inverted carry of A + ~B + 1.

Test Plan:
- Reset, then idle: out_valid=0, in_ready=1, D=0x00, BOUT=0 for 20 cycles with in_valid=0.
- WIDTH=8, A=0x5A, B=0x23, out_ready=1: out_valid=1 exactly 8 cycles after the handshake with D=0x37, BOUT=0. in_ready returns to 1 one cycle after acceptance.
- Underflow and equality:
  - A=0x00, B=0x01 gives D=0xFF, BOUT=1.
  - A=0x80, B=0x80 gives D=0x00, BOUT=0.
  - A=0x00, B=0xFF gives D=0x01, BOUT=1.
- Backpressure and busy input:
  - out_ready=0 for 10 cycles in DONE: D/BOUT/out_valid stay constant; then out_ready=1 completes the transfer.
  - in_valid pulsed with A=0xFF, B=0x00 during SHIFT: no effect on the current result.
- Reset mid-op: rst=1 at the 4th SHIFT cycle of A=0x5A, B=0x23. out_valid never rises for that op; state=IDLE and D=0 next cycle. A following op A=0x10, B=0x01 gives D=0x0F.
- Back-to-back ops with in_valid and out_ready held high, plus randomized sweep: 1000 random A/B pairs at WIDTH=8 and WIDTH=1. Every result matches the reference model (A-B) mod 2^WIDTH, BOUT=(A<B), and a new handshake occurs every WIDTH+2 cycles.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. Computes D = A - B (mod 2^WIDTH) one bit
//   per clock, LSB first, with a registered borrow. BOUT is the final borrow,
//   set iff A < B.
//
// Handshake semantics (both interfaces): a transfer happens on a rising edge
//   where valid and ready are both high. in_ready and out_valid are registered
//   state flags, so neither depends combinationally on the opposite side.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operands A/B presented
//   in_ready     block accepts operands (high only in IDLE)
//   A, B         minuend / subtrahend, sampled on the input handshake
//   out_valid    D/BOUT valid (high only in DONE)
//   out_ready    consumer accepts the result
//   D            difference, held until the next operation completes
//   BOUT         final borrow
//   o_dbg_state  current FSM state (0=IDLE, 1=SHIFT, 2=DONE)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic [1:0]       o_dbg_state
);

  // Counter holds 0..WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  logic             w_d_bit;
  logic             w_borrow_next;
  logic [WIDTH-1:0] w_res_next;

  // One full-subtractor slice on the current LSBs.
  assign w_d_bit       = r_a_sh[0] ^ r_b_sh[0] ^ r_borrow;
  assign w_borrow_next = (~r_a_sh[0] & r_b_sh[0]) |
                         (~(r_a_sh[0] ^ r_b_sh[0]) & r_borrow);
  // New difference bit enters at the MSB; after WIDTH shifts bit i is diff bit i.
  assign w_res_next    = (r_res_sh >> 1) | (WIDTH'(w_d_bit) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_res_sh    <= '0;
      r_cnt       <= '0;
      r_borrow    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_d         <= '0;
      r_bout      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh     <= A;
            r_b_sh     <= B;
            r_res_sh   <= '0;
            r_borrow   <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res_sh <= w_res_next;
          r_borrow <= w_borrow_next;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_d         <= w_res_next;
            r_bout      <= w_borrow_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // Result stays put until the consumer takes it.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign D           = r_d;
  assign BOUT        = r_bout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Bench for serial_subtractor with two instances: WIDTH=8 (directed and
//   random scenarios) and WIDTH=1 (random sweep). Expected results come from
//   plain integer arithmetic on the operands.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic       in_ready, out_valid, bout;
  logic [7:0] d;
  logic [1:0] st;

  logic       in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic [0:0] a1 = '0, b1 = '0;
  logic       in_ready1, out_valid1, bout1;
  logic [0:0] d1;
  logic [1:0] st1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] exp_q8[$];
  logic [1:0] exp_q1[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready),
    .D(d), .BOUT(bout), .o_dbg_state(st)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(a1), .B(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .D(d1), .BOUT(bout1), .o_dbg_state(st1)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: {borrow, difference}
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y);
    int diff;
    diff = (int'(x) - int'(y) + 256) % 256;
    return {(x < y), 8'(diff)};
  endfunction

  function automatic logic [1:0] ref1(input logic [0:0] x, input logic [0:0] y);
    int diff;
    diff = (int'(x) - int'(y) + 2) % 2;
    return {(x < y), 1'(diff)};
  endfunction

  // Driver tasks (called at posedge+1 with the DUT idle)
  task automatic hs8(input logic [7:0] aa, input logic [7:0] bb);
    a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid8(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scenarios
  task automatic test_reset;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({out_valid, in_ready, d, bout} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
        $display("FAIL reset_idle8 cyc %0d: got ov=%b ir=%b d=%h b=%b, exp ov=0 ir=1 d=00 b=0",
                 i, out_valid, in_ready, d, bout);
      end else n_pass++;
      n_checks++;
      if ({out_valid1, in_ready1, d1, bout1} !== {1'b0, 1'b1, 1'b0, 1'b0}) begin
        $display("FAIL reset_idle1 cyc %0d: got ov=%b ir=%b d=%h b=%b, exp ov=0 ir=1 d=0 b=0",
                 i, out_valid1, in_ready1, d1, bout1);
      end else n_pass++;
      step(1);
    end
  endtask

  task automatic test_basic;
    int cyc;
    out_ready = 1'b1;
    hs8(8'h5A, 8'h23);
    wait_valid8(cyc);
    n_checks++;
    if (cyc !== 8) $display("FAIL basic_latency: got %0d cycles, exp 8", cyc);
    else n_pass++;
    n_checks++;
    if ({bout, d} !== {1'b0, 8'h37}) $display("FAIL basic_result: got b=%b d=%h, exp b=0 d=37", bout, d);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL basic_busy_ready: got %b, exp 0", in_ready);
    else n_pass++;
    step(1);
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) $display("FAIL basic_release: got ir=%b ov=%b, exp ir=1 ov=0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_edges;
    logic [7:0] ta[3];
    logic [7:0] tb[3];
    logic [8:0] exp;
    int cyc;
    ta[0] = 8'h00; tb[0] = 8'h01;
    ta[1] = 8'h80; tb[1] = 8'h80;
    ta[2] = 8'h00; tb[2] = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = ref8(ta[i], tb[i]);
      hs8(ta[i], tb[i]);
      wait_valid8(cyc);
      n_checks++;
      if ({bout, d} !== exp || cyc !== 8)
        $display("FAIL edge_%0d A=%h B=%h: got b=%b d=%h lat=%0d, exp b=%b d=%h lat=8",
                 i, ta[i], tb[i], bout, d, cyc, exp[8], exp[7:0]);
      else n_pass++;
      step(1);
    end
  endtask

  task automatic test_backpressure;
    logic [8:0] exp;
    int cyc;
    out_ready = 1'b0;
    exp = ref8(8'hC3, 8'h4E);
    hs8(8'hC3, 8'h4E);
    wait_valid8(cyc);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({out_valid, bout, d} !== {1'b1, exp})
        $display("FAIL bp_hold cyc %0d: got ov=%b b=%b d=%h, exp ov=1 b=%b d=%h",
                 i, out_valid, bout, d, exp[8], exp[7:0]);
      else n_pass++;
      step(1);
    end
    out_ready = 1'b1;
    step(1);
    n_checks++;
    if ({out_valid, in_ready, bout, d} !== {2'b01, exp})
      $display("FAIL bp_release: got ov=%b ir=%b b=%b d=%h, exp ov=0 ir=1 b=%b d=%h",
               out_valid, in_ready, bout, d, exp[8], exp[7:0]);
    else n_pass++;
  endtask

  task automatic test_busy_input;
    logic [8:0] exp;
    int cyc;
    out_ready = 1'b1;
    exp = ref8(8'h3C, 8'h15);
    hs8(8'h3C, 8'h15);
    step(1);
    a = 8'hFF; b = 8'h00; in_valid = 1'b1;
    step(2);
    in_valid = 1'b0;
    wait_valid8(cyc);
    n_checks++;
    if ({bout, d} !== exp || cyc !== 5)
      $display("FAIL busy_input: got b=%b d=%h wait=%0d, exp b=%b d=%h wait=5",
               bout, d, cyc, exp[8], exp[7:0]);
    else n_pass++;
    step(1);
  endtask

  task automatic test_reset_mid;
    int seen;
    int cyc;
    out_ready = 1'b1;
    hs8(8'h5A, 8'h23);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_checks++;
    if ({st, d, out_valid, in_ready} !== {2'd0, 8'h00, 1'b0, 1'b1})
      $display("FAIL reset_mid_state: got st=%0d d=%h ov=%b ir=%b, exp st=0 d=00 ov=0 ir=1",
               st, d, out_valid, in_ready);
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) seen++;
      step(1);
    end
    n_checks++;
    if (seen !== 0) $display("FAIL reset_mid_no_result: got %0d valid cycles, exp 0", seen);
    else n_pass++;
    hs8(8'h10, 8'h01);
    wait_valid8(cyc);
    n_checks++;
    if ({bout, d} !== {1'b0, 8'h0F}) $display("FAIL reset_mid_next: got b=%b d=%h, exp b=0 d=0F", bout, d);
    else n_pass++;
    step(1);
  endtask

  // Both instances run back-to-back with in_valid and out_ready held high.
  task automatic test_back_to_back;
    int cyc = 0, hs8_n = 0, hs1_n = 0, last8 = 0, last1 = 0;
    bit upd8 = 1'b0, upd1 = 1'b0;
    logic [8:0] e8;
    logic [1:0] e1;
    out_ready = 1'b1; out_ready1 = 1'b1;
    a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
    a1 = 1'($urandom); b1 = 1'($urandom); in_valid1 = 1'b1;
    while ((hs8_n < 1000 || hs1_n < 1000 || exp_q8.size() > 0 || exp_q1.size() > 0) && cyc < 20000) begin
      if (upd8) begin
        a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
        if (hs8_n >= 1000) in_valid = 1'b0;
        upd8 = 1'b0;
      end
      if (upd1) begin
        a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
        if (hs1_n >= 1000) in_valid1 = 1'b0;
        upd1 = 1'b0;
      end
      if (out_valid === 1'b1) begin
        n_checks++;
        if (exp_q8.size() == 0) $display("FAIL b2b8_spurious: result d=%h with nothing expected", d);
        else begin
          e8 = exp_q8.pop_front();
          if ({bout, d} !== e8) $display("FAIL b2b8_result: got b=%b d=%h, exp b=%b d=%h", bout, d, e8[8], e8[7:0]);
          else n_pass++;
        end
      end
      if (out_valid1 === 1'b1) begin
        n_checks++;
        if (exp_q1.size() == 0) $display("FAIL b2b1_spurious: result d=%b with nothing expected", d1);
        else begin
          e1 = exp_q1.pop_front();
          if ({bout1, d1} !== e1) $display("FAIL b2b1_result: got b=%b d=%b, exp b=%b d=%b", bout1, d1, e1[1], e1[0]);
          else n_pass++;
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        exp_q8.push_back(ref8(a, b));
        if (hs8_n > 0) begin
          n_checks++;
          if (cyc - last8 !== 10) $display("FAIL b2b8_interval: got %0d, exp 10", cyc - last8);
          else n_pass++;
        end
        last8 = cyc; hs8_n++; upd8 = 1'b1;
      end
      if (in_valid1 && in_ready1 === 1'b1) begin
        exp_q1.push_back(ref1(a1, b1));
        if (hs1_n > 0) begin
          n_checks++;
          if (cyc - last1 !== 3) $display("FAIL b2b1_interval: got %0d, exp 3", cyc - last1);
          else n_pass++;
        end
        last1 = cyc; hs1_n++; upd1 = 1'b1;
      end
      step(1);
      cyc++;
    end
    in_valid = 1'b0; in_valid1 = 1'b0;
    n_checks++;
    if (cyc >= 20000) $display("FAIL b2b_timeout: got hs8=%0d hs1=%0d, exp 1000 each", hs8_n, hs1_n);
    else n_pass++;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_basic;
    test_edges;
    test_backpressure;
    test_busy_input;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
